adder_arbiter: RTL

Round-robin scheduler that shares one 32-bit prefix adder among `NREQ` requesters. Each requester issues add or subtract operations over a valid/ready handshake. The winning operands drive the shared adder combinationally, and the result is captured in a single-entry response register tagged with the requester index. The block sits between the client units and the `prefix_adder` instance, and owns all of the adder's input muxing.

---
 rtl/adder_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : adder_arbiter
// Purpose  : Round-robin scheduler sharing one external 32-bit prefix adder
//            among NREQ requesters. The winning requester's operands drive the
//            adder combinationally; the result is captured in a single-entry
//            response register tagged with the requester index.
// Options  : ADDARB_CARRY_CHAIN_EN - when defined, keeps one stored carry per
//            requester so req_chain can feed it back as carry-in (multi-word
//            add / subtract-with-borrow). When undefined, req_chain is ignored.
// Ports    : clk, rst_n                 clock, synchronous active-low reset
//            req_valid/req_ready        per-requester handshake (ready one-hot)
//            req_a/req_b                packed operands, requester i at [32i+:32]
//            req_sub/req_chain          per-requester op select / carry chain
//            add_a/add_b/add_cin        operands to the prefix adder
//            add_s/add_cout             result from the prefix adder
//            rsp_valid/rsp_ready        response handshake
//            rsp_id/rsp_sum/rsp_cout    registered result and its source index
// Revision : 1.0 - initial release
// ============================================================================
module adder_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ-1:0]      req_sub,
    input  logic [NREQ-1:0]      req_chain,
    output logic [31:0]          add_a,
    output logic [31:0]          add_b,
    output logic                 add_cin,
    input  logic [31:0]          add_s,
    input  logic                 add_cout,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_sum,
    output logic                 rsp_cout
);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IDW-1:0]  r_rr;
    logic [IDW-1:0]  r_id;
    logic [31:0]     r_sum;
    logic            r_cout;

    logic            w_grant_en;
    logic            w_grant;
    logic [IDW-1:0]  w_gnt_idx;
    logic            w_hi_found;
    logic [IDW-1:0]  w_hi_idx;
    logic            w_lo_found;
    logic [IDW-1:0]  w_lo_idx;

`ifdef ADDARB_CARRY_CHAIN_EN
    logic [NREQ-1:0] r_carry;
`else
    // req_chain has no effect without stored carries.
    logic            w_unused_chain;
    assign w_unused_chain = ^req_chain;
`endif

    // Gating with rst_n keeps req_ready low and suppresses any grant while
    // reset is asserted.
    assign w_grant_en = rst_n & ((r_state == S_EMPTY) | rsp_ready);

    // Round-robin search: the lowest valid index at or above rr wins; if none
    // exists the search wraps and the lowest valid index overall wins.
    // Scanning downward lets the last hit be the lowest index.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_found = 1'b0;
        w_lo_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_lo_found = 1'b1;
                w_lo_idx   = IDW'(i);
                if (i >= int'(r_rr)) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = IDW'(i);
                end
            end
        end
    end

    assign w_gnt_idx = w_hi_found ? w_hi_idx : w_lo_idx;
    assign w_grant   = w_lo_found & w_grant_en;

    // One-hot ready and the operand mux; everything is zero with no grant.
    always_comb begin
        req_ready = '0;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant && (w_gnt_idx == IDW'(i))) begin
                req_ready[i] = 1'b1;
                add_a        = req_a[32*i +: 32];
                // Subtraction is A + ~B + 1.
                add_b        = req_sub[i] ? ~req_b[32*i +: 32] : req_b[32*i +: 32];
`ifdef ADDARB_CARRY_CHAIN_EN
                // A chained word replaces the +1 with the stored carry, which
                // for subtraction is the inverted borrow of the lower word.
                add_cin      = req_chain[i] ? r_carry[i] : req_sub[i];
`else
                add_cin      = req_sub[i];
`endif
            end
        end
    end

    // Response register occupancy.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_grant) w_state_nxt = S_FULL;
            S_FULL:  if (rsp_ready && !w_grant) w_state_nxt = S_EMPTY;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
            r_rr    <= '0;
            r_id    <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_rr   <= (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + IDW'(1);
                r_id   <= w_gnt_idx;
                r_sum  <= add_s;
                r_cout <= add_cout;
            end
        end
    end

`ifdef ADDARB_CARRY_CHAIN_EN
    // Only the granted requester's carry is refreshed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_carry <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_grant && (w_gnt_idx == IDW'(i))) begin
                    r_carry[i] <= add_cout;
                end
            end
        end
    end
`endif

    assign rsp_valid = (r_state == S_FULL);
    assign rsp_id    = r_id;
    assign rsp_sum   = r_sum;
    assign rsp_cout  = r_cout;

endmodule
`default_nettype wire
